// File: rtl/mmu_tlb.sv
// mmu_tlb: fully associative TLB with a single outstanding request,
// an external page-walk refill handshake and a captured fault register.
// Addresses on the ports omit the low RV/16 bits (naturally aligned accesses).
module mmu_tlb #(
    parameter int RV    = 16,
    parameter int VA    = RV,
    parameter int PA    = RV,
    parameter int VPNW  = 3,
    parameter int NENT  = 4,
    parameter int ASIDW = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          mmu_enable,
    input  logic                          supmode,
    input  logic [ASIDW-1:0]              asid,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_is_pc,
    input  logic                          req_is_write,
    input  logic [VA-1:RV/16]             req_va,
    output logic                          rsp_valid,
    output logic [PA-1:RV/16]             rsp_pa,
    output logic                          rsp_miss_fault,
    output logic                          rsp_prot_fault,
    output logic                          refill_req,
    output logic [ASIDW+VPNW:0]           refill_tag,
    input  logic                          refill_ack,
    input  logic [PA-(VA-VPNW)+2:0]       refill_data,
    input  logic                          inv_all,
    input  logic                          inv_asid,
    input  logic [ASIDW-1:0]              inv_asid_val,
    output logic [RV-1:0]                 reg_read
);
    localparam int UNTOUCHED = VA - VPNW;
    localparam int PPNW      = PA - UNTOUCHED;
    localparam int AL        = RV / 16;
    localparam int IDXW      = (NENT > 1) ? $clog2(NENT) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    // Entry storage
    logic [NENT-1:0]  r_valid;
    logic [NENT-1:0]  r_sup;
    logic [NENT-1:0]  r_wr;
    logic [NENT-1:0]  r_ex;
    logic [ASIDW-1:0] r_asid [NENT];
    logic [VPNW-1:0]  r_vpn  [NENT];
    logic [PPNW-1:0]  r_ppn  [NENT];
    logic [IDXW-1:0]  r_rr;

    // Control and the registered (outstanding) request
    logic [1:0]             r_state;
    logic [VA-1:AL]         r_req_va;
    logic                   r_req_pc;
    logic                   r_req_wr;
    logic                   r_req_sup;
    logic [ASIDW-1:0]       r_req_asid;

    // Response registers
    logic                   r_rsp_valid;
    logic [PA-1:AL]         r_rsp_pa;
    logic                   r_rsp_miss;
    logic                   r_rsp_prot;

    // Fault capture register
    logic [VPNW-1:0]        r_fault_vpn;
    logic                   r_fault_ins;
    logic                   r_fault_sup;
    logic                   r_fault_type;

    logic                   w_accept;
    logic [VPNW-1:0]        w_req_vpn;
    logic [UNTOUCHED-1:AL]  w_req_off;
    logic [PA-1:AL]         w_bypass_pa;
    logic [NENT-1:0]        w_hit_vec;
    logic                   w_hit;
    logic [IDXW-1:0]        w_hit_idx;
    logic [PPNW-1:0]        w_hit_ppn;
    logic                   w_hit_prot;
    logic [IDXW-1:0]        w_victim;
    logic [PPNW-1:0]        w_rf_ppn;
    logic                   w_rf_valid;
    logic                   w_rf_wr;
    logic                   w_rf_ex;
    logic                   w_rf_prot;
    logic                   w_install;

    assign req_ready   = (r_state == S_IDLE) & ~inv_all & ~inv_asid;
    assign w_accept    = req_valid & req_ready;
    assign w_req_vpn   = req_va[VA-1:UNTOUCHED];
    assign w_req_off   = req_va[UNTOUCHED-1:AL];
    // Untranslated path: the virtual address is passed through, zero-extended
    assign w_bypass_pa = (PA-AL)'(req_va);

    // Per-entry tag compare: {sup, asid, vpn} must all match a valid entry
    for (genvar gi = 0; gi < NENT; gi++) begin : g_cmp
        assign w_hit_vec[gi] = r_valid[gi] && (r_sup[gi] == supmode) &&
                               (r_asid[gi] == asid) && (r_vpn[gi] == w_req_vpn);
    end
    assign w_hit = |w_hit_vec;

    // Select the lowest-index matching entry
    always_comb begin
        w_hit_idx = '0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (w_hit_vec[i]) w_hit_idx = IDXW'(i);
        end
    end

    assign w_hit_ppn  = r_ppn[w_hit_idx];
    assign w_hit_prot = (req_is_write & ~r_wr[w_hit_idx]) | (req_is_pc & ~r_ex[w_hit_idx]);

    // Victim: lowest-index free slot, otherwise the round-robin slot
    always_comb begin
        w_victim = r_rr;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_victim = IDXW'(i);
        end
    end

    assign w_rf_ppn   = refill_data[PPNW+2:3];
    assign w_rf_valid = refill_data[2];
    assign w_rf_wr    = refill_data[1];
    assign w_rf_ex    = refill_data[0];
    assign w_rf_prot  = (r_req_wr & ~w_rf_wr) | (r_req_pc & ~w_rf_ex);
    // refill_ack is only meaningful while a walk is outstanding
    assign w_install  = (r_state == S_REFILL) & refill_ack & w_rf_valid;

    // Valid bits and replacement pointer; an install in the same edge as an
    // invalidation wins for the installed slot so the walk is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_rr    <= '0;
        end else begin
            for (int i = 0; i < NENT; i++) begin
                if (inv_all || (inv_asid && !r_sup[i] && (r_asid[i] == inv_asid_val)))
                    r_valid[i] <= 1'b0;
            end
            if (w_install) begin
                r_valid[w_victim] <= 1'b1;
                r_rr              <= r_rr + IDXW'(1);
            end
        end
    end

    // Entry payload written on install; meaningless while the slot is invalid
    always_ff @(posedge clk) begin
        if (w_install) begin
            r_sup[w_victim]  <= r_req_sup;
            r_asid[w_victim] <= r_req_asid;
            r_vpn[w_victim]  <= r_req_va[VA-1:UNTOUCHED];
            r_ppn[w_victim]  <= w_rf_ppn;
            r_wr[w_victim]   <= w_rf_wr;
            r_ex[w_victim]   <= w_rf_ex;
        end
    end

    // Request FSM, response generation and fault capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_req_va     <= '0;
            r_req_pc     <= 1'b0;
            r_req_wr     <= 1'b0;
            r_req_sup    <= 1'b0;
            r_req_asid   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_pa     <= '0;
            r_rsp_miss   <= 1'b0;
            r_rsp_prot   <= 1'b0;
            r_fault_vpn  <= '0;
            r_fault_ins  <= 1'b0;
            r_fault_sup  <= 1'b0;
            r_fault_type <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_miss  <= 1'b0;
            r_rsp_prot  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_req_va   <= req_va;
                        r_req_pc   <= req_is_pc;
                        r_req_wr   <= req_is_write;
                        r_req_sup  <= supmode;
                        r_req_asid <= asid;
                        if (!mmu_enable) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_pa    <= w_bypass_pa;
                        end else if (w_hit) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_pa    <= {w_hit_ppn, w_req_off};
                            r_rsp_prot  <= w_hit_prot;
                            if (w_hit_prot) begin
                                r_fault_vpn  <= w_req_vpn;
                                r_fault_ins  <= req_is_pc;
                                r_fault_sup  <= supmode;
                                r_fault_type <= 1'b0;
                            end
                        end else begin
                            r_state <= S_REFILL;
                        end
                    end
                end
                S_REFILL: begin
                    if (refill_ack) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        if (w_rf_valid) begin
                            r_rsp_pa   <= {w_rf_ppn, r_req_va[UNTOUCHED-1:AL]};
                            r_rsp_prot <= w_rf_prot;
                            if (w_rf_prot) begin
                                r_fault_vpn  <= r_req_va[VA-1:UNTOUCHED];
                                r_fault_ins  <= r_req_pc;
                                r_fault_sup  <= r_req_sup;
                                r_fault_type <= 1'b0;
                            end
                        end else begin
                            r_rsp_miss   <= 1'b1;
                            r_fault_vpn  <= r_req_va[VA-1:UNTOUCHED];
                            r_fault_ins  <= r_req_pc;
                            r_fault_sup  <= r_req_sup;
                            r_fault_type <= 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_pa         = r_rsp_pa;
    assign rsp_miss_fault = r_rsp_miss;
    assign rsp_prot_fault = r_rsp_prot;
    assign refill_req     = (r_state == S_REFILL);
    assign refill_tag     = {r_req_sup, r_req_asid, r_req_va[VA-1:UNTOUCHED]};
    assign reg_read       = {r_fault_vpn, {(RV-VPNW-4){1'b0}},
                             r_fault_ins, r_fault_sup, r_fault_type, 1'b0};

endmodule

// File: tb/tb_mmu_tlb.sv
// tb_mmu_tlb: table-driven transactions with a response scoreboard,
// plus hand-written invalidation, stray-ack and reset-abandon sequences.
module tb_mmu_tlb;
    logic        clk = 1'b0;
    logic        reset;
    logic        mmu_enable;
    logic        supmode;
    logic [3:0]  asid;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_pc;
    logic        req_is_write;
    logic [15:1] req_va;
    logic        rsp_valid;
    logic [15:1] rsp_pa;
    logic        rsp_miss_fault;
    logic        rsp_prot_fault;
    logic        refill_req;
    logic [7:0]  refill_tag;
    logic        refill_ack;
    logic [5:0]  refill_data;
    logic        inv_all;
    logic        inv_asid;
    logic [3:0]  inv_asid_val;
    logic [15:0] reg_read;

    always #5 clk = ~clk;

    mmu_tlb dut (
        .clk(clk), .reset(reset), .mmu_enable(mmu_enable), .supmode(supmode),
        .asid(asid), .req_valid(req_valid), .req_ready(req_ready),
        .req_is_pc(req_is_pc), .req_is_write(req_is_write), .req_va(req_va),
        .rsp_valid(rsp_valid), .rsp_pa(rsp_pa), .rsp_miss_fault(rsp_miss_fault),
        .rsp_prot_fault(rsp_prot_fault), .refill_req(refill_req),
        .refill_tag(refill_tag), .refill_ack(refill_ack), .refill_data(refill_data),
        .inv_all(inv_all), .inv_asid(inv_asid), .inv_asid_val(inv_asid_val),
        .reg_read(reg_read)
    );

    typedef struct {
        logic [15:0] va;
        logic        en;
        logic        sup;
        logic [3:0]  asid;
        logic        pc;
        logic        wr;
        logic        refill;
        logic [7:0]  tag;
        logic [5:0]  rdata;
        logic        inv_ack;
        logic        chk_pa;
        logic [15:0] pa;
        logic        miss;
        logic        prot;
        logic [15:0] regv;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] pa;
        logic        chk_pa;
        logic        miss;
        logic        prot;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_rsp    = 0;

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, id, act, exp);
    endtask

    task automatic add(input logic [15:0] va, input logic en, input logic sup, input logic [3:0] a,
                       input logic pc, input logic wr, input logic refill, input logic [7:0] tag,
                       input logic [5:0] rdata, input logic inv_ack, input logic chk_pa,
                       input logic [15:0] pa, input logic miss, input logic prot, input logic [15:0] regv);
        vec_t v;
        v.va = va; v.en = en; v.sup = sup; v.asid = a; v.pc = pc; v.wr = wr;
        v.refill = refill; v.tag = tag; v.rdata = rdata; v.inv_ack = inv_ack;
        v.chk_pa = chk_pa; v.pa = pa; v.miss = miss; v.prot = prot; v.regv = regv;
        tbl.push_back(v);
    endtask

    // Scoreboard: every response strobe is matched against the oldest expectation
    always @(negedge clk) begin
        if (rsp_valid) begin
            n_rsp++;
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", -1, 32'(1), 32'(0));
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_pa) check("rsp_pa", mon_e.id, 32'({rsp_pa, 1'b0}), 32'(mon_e.pa));
                check("miss_fault", mon_e.id, 32'(rsp_miss_fault), 32'(mon_e.miss));
                check("prot_fault", mon_e.id, 32'(rsp_prot_fault), 32'(mon_e.prot));
            end
        end
    end

    task automatic run_vec(input int idx);
        vec_t v;
        exp_t e;
        v = tbl[idx];
        @(negedge clk);
        check("req_ready", idx, 32'(req_ready), 32'(1));
        mmu_enable   = v.en;
        supmode      = v.sup;
        asid         = v.asid;
        req_is_pc    = v.pc;
        req_is_write = v.wr;
        req_va       = v.va[15:1];
        req_valid    = 1'b1;
        e.id = idx; e.pa = v.pa; e.chk_pa = v.chk_pa; e.miss = v.miss; e.prot = v.prot;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (v.refill) begin
            check("refill_req", idx, 32'(refill_req), 32'(1));
            check("refill_tag", idx, 32'(refill_tag), 32'(v.tag));
            check("early_rsp", idx, 32'(rsp_valid), 32'(0));
            @(negedge clk);
            check("tag_hold", idx, 32'(refill_tag), 32'(v.tag));
            refill_ack  = 1'b1;
            refill_data = v.rdata;
            inv_all     = v.inv_ack;
            if (v.inv_ack) begin
                #1;
                check("ready_inv", idx, 32'(req_ready), 32'(0));
            end
            @(negedge clk);
            refill_ack  = 1'b0;
            inv_all     = 1'b0;
            refill_data = 6'h00;
        end
        check("rsp_valid", idx, 32'(rsp_valid), 32'(1));
        check("no_refill", idx, 32'(refill_req), 32'(0));
        @(negedge clk);
        check("rsp_pulse", idx, 32'(rsp_valid), 32'(0));
        check("reg_read", idx, 32'(reg_read), 32'(v.regv));
        $display("vec %0d va=0x%04h en=%0b sup=%0b asid=%0d pc=%0b wr=%0b refill=%0b exp_pa=0x%04h",
                 idx, v.va, v.en, v.sup, v.asid, v.pc, v.wr, v.refill, v.pa);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mmu_enable = 1'b0; supmode = 1'b0; asid = 4'd0;
        req_valid = 1'b0; req_is_pc = 1'b0; req_is_write = 1'b0; req_va = '0;
        refill_ack = 1'b0; refill_data = 6'h00; inv_all = 1'b0; inv_asid = 1'b0;
        inv_asid_val = 4'd0;

        //   va        en sup asid pc wr rf tag    rdata      inv chk pa        mi pr reg
        add(16'h4A12, 0, 0, 4'd1, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'h4A12, 0, 0, 16'h0000); // 0 bypass
        add(16'h4A12, 1, 0, 4'd1, 0, 0, 1, 8'h0A, 6'b101110, 0, 1, 16'hAA12, 0, 0, 16'h0000); // 1 refill
        add(16'h4A12, 1, 0, 4'd1, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'hAA12, 0, 0, 16'h0000); // 2 hit
        add(16'h4A12, 1, 0, 4'd1, 1, 0, 0, 8'h00, 6'b000000, 0, 1, 16'hAA12, 0, 1, 16'h4008); // 3 exec prot
        add(16'h4000, 1, 0, 4'd2, 0, 1, 1, 8'h12, 6'b011101, 0, 1, 16'h6000, 0, 1, 16'h4000); // 4 write prot after refill
        add(16'h4002, 1, 0, 4'd2, 0, 1, 0, 8'h00, 6'b000000, 0, 1, 16'h6002, 0, 1, 16'h4000); // 5 write prot hit
        add(16'h4ABC, 1, 0, 4'd2, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'h6ABC, 0, 0, 16'h4000); // 6 read ok
        add(16'h2010, 1, 1, 4'd1, 0, 0, 1, 8'h89, 6'b111011, 0, 0, 16'h0000, 1, 0, 16'h2006); // 7 walk miss
        add(16'h2010, 1, 1, 4'd1, 0, 0, 1, 8'h89, 6'b111111, 0, 1, 16'hE010, 0, 0, 16'h2006); // 8 not installed before
        add(16'h2010, 1, 0, 4'd1, 0, 0, 1, 8'h09, 6'b010111, 0, 1, 16'h4010, 0, 0, 16'h2006); // 9 user != sup
        add(16'hE000, 1, 0, 4'd1, 1, 0, 1, 8'h0F, 6'b001101, 0, 1, 16'h2000, 0, 0, 16'h2006); // 10 5th -> slot0
        add(16'h4A12, 1, 0, 4'd1, 0, 0, 1, 8'h0A, 6'b110111, 0, 1, 16'hCA12, 0, 0, 16'h2006); // 11 6th -> slot1
        add(16'h4ABC, 1, 0, 4'd2, 0, 0, 1, 8'h12, 6'b011111, 0, 1, 16'h6ABC, 0, 0, 16'h2006); // 12
        add(16'h2010, 1, 1, 4'd1, 0, 0, 1, 8'h89, 6'b111111, 0, 1, 16'hE010, 0, 0, 16'h2006); // 13
        add(16'hE004, 1, 0, 4'd1, 1, 0, 0, 8'h00, 6'b000000, 0, 1, 16'h2004, 0, 0, 16'h2006); // 14 hit slot0
        add(16'h4A12, 1, 0, 4'd1, 0, 0, 1, 8'h0A, 6'b110111, 0, 1, 16'hCA12, 0, 0, 16'h2006); // 15 after inv_asid
        add(16'h2010, 1, 1, 4'd1, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'hE010, 0, 0, 16'h2006); // 16 sup survives
        add(16'h4ABC, 1, 0, 4'd2, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'h6ABC, 0, 0, 16'h2006); // 17 asid2 survives
        add(16'hE004, 1, 0, 4'd1, 1, 0, 1, 8'h0F, 6'b001101, 0, 1, 16'h2004, 0, 0, 16'h2006); // 18
        add(16'h2222, 1, 0, 4'd2, 0, 0, 1, 8'h11, 6'b100111, 1, 1, 16'h8222, 0, 0, 16'h2006); // 19 inv_all at ack
        add(16'h2222, 1, 0, 4'd2, 0, 0, 0, 8'h00, 6'b000000, 0, 1, 16'h8222, 0, 0, 16'h2006); // 20 install kept
        add(16'h4ABC, 1, 0, 4'd2, 0, 0, 1, 8'h12, 6'b011111, 0, 1, 16'h6ABC, 0, 0, 16'h2006); // 21 flushed
        add(16'h2010, 1, 1, 4'd1, 0, 0, 1, 8'h89, 6'b111111, 0, 1, 16'hE010, 0, 0, 16'h2006); // 22 flushed
        add(16'h2222, 1, 0, 4'd2, 0, 0, 1, 8'h11, 6'b100011, 0, 0, 16'h0000, 1, 0, 16'h2002); // 23 after reset
        add(16'hFFFE, 0, 0, 4'd2, 1, 1, 0, 8'h00, 6'b000000, 0, 1, 16'hFFFE, 0, 0, 16'h2002); // 24 bypass, no fault

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", -1, 32'(rsp_valid), 32'(0));
        check("rst_refill_req", -1, 32'(refill_req), 32'(0));
        check("rst_reg_read", -1, 32'(reg_read), 32'(0));
        check("rst_req_ready", -1, 32'(req_ready), 32'(1));
        reset = 1'b0;

        for (int i = 0; i <= 14; i++) run_vec(i);

        // Drop user entries of address space 1
        @(negedge clk);
        inv_asid = 1'b1; inv_asid_val = 4'd1;
        #1;
        check("ready_inv_asid", -1, 32'(req_ready), 32'(0));
        @(negedge clk);
        inv_asid = 1'b0;
        #1;
        check("ready_after_inv", -1, 32'(req_ready), 32'(1));
        $display("seq inv_asid asid=1");

        for (int i = 15; i <= 22; i++) run_vec(i);

        // A stray acknowledge while idle must produce nothing
        @(negedge clk);
        refill_ack = 1'b1; refill_data = 6'b101111;
        @(negedge clk);
        refill_ack = 1'b0; refill_data = 6'h00;
        check("stray_ack_rsp", -1, 32'(rsp_valid), 32'(0));
        check("stray_ack_refill", -1, 32'(refill_req), 32'(0));
        $display("seq stray refill_ack");

        // Reset while a walk is outstanding abandons the request
        @(negedge clk);
        mmu_enable = 1'b1; supmode = 1'b0; asid = 4'd3; req_is_pc = 1'b0;
        req_is_write = 1'b0; req_va = 15'h3000; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_rst_refill", -1, 32'(refill_req), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_refill", -1, 32'(refill_req), 32'(0));
        check("post_rst_rsp", -1, 32'(rsp_valid), 32'(0));
        @(negedge clk);
        check("post_rst_rsp2", -1, 32'(rsp_valid), 32'(0));
        check("post_rst_ready", -1, 32'(req_ready), 32'(1));
        check("post_rst_reg", -1, 32'(reg_read), 32'(0));
        $display("seq reset during refill");

        for (int i = 23; i <= 24; i++) run_vec(i);

        repeat (3) @(negedge clk);
        check("sb_empty", -1, 32'(sb_q.size()), 32'(0));
        check("rsp_count", -1, 32'(n_rsp), 32'(25));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mmu_tlb.md
MMU_TLB -- requirements
Module: mmu_tlb

Interface
REQ-001 Parameters SHALL be: RV, default 16, machine word width; VA, default RV, virtual address width; PA, default RV, physical address width; VPNW, default 3, virtual page number width; NENT, default 4, TLB entries (power of 2, >=2); ASIDW, default 4, address-space ID width.
REQ-002 Derived widths SHALL be: UNTOUCHED=VA-VPNW (page offset top bit+1); PPNW=PA-UNTOUCHED.
REQ-003 Ports SHALL be (name dir width meaning): clk in 1 clock; reset in 1 synchronous active-high reset; mmu_enable in 1 translation on; supmode in 1 supervisor access; asid in ASIDW current address space; req_valid in 1 request; req_ready out 1 request accepted; req_is_pc in 1 fetch (else data); req_is_write in 1 data write; req_va in VA-RV/16 address [VA-1:RV/16]; rsp_valid out 1 response strobe; rsp_pa out PA-RV/16 address [PA-1:RV/16]; rsp_miss_fault out 1; rsp_prot_fault out 1; refill_req out 1 walk request; refill_tag out 1+ASIDW+VPNW {sup,asid,vpn}; refill_ack in 1; refill_data in PPNW+3 {ppn,valid,writeable,executable}; inv_all in 1; inv_asid in 1; inv_asid_val in ASIDW; reg_read out RV fault register.

Function
REQ-004 Entry SHALL hold valid, sup, asid, vpn, ppn, writeable, executable; lookup tag = {supmode, asid, req_va[VA-1:UNTOUCHED]}, hit = valid and full tag match.
REQ-005 FSM states SHALL be IDLE, REFILL, RESP; req_ready=1 only in IDLE with inv_all=0 and inv_asid=0.
REQ-006 Accepted request with mmu_enable=0: next cycle rsp_valid=1, rsp_pa=zero-extended req_va, both faults 0; state stays IDLE.
REQ-007 Accepted hit: next cycle rsp_valid=1, rsp_pa={ppn, req_va[UNTOUCHED-1:RV/16]}; rsp_prot_fault=1 if (req_is_write & !writeable) or (req_is_pc & !executable).
REQ-008 Accepted miss: request registered, state -> REFILL; refill_req=1 and refill_tag stable from next cycle until the cycle refill_ack=1 inclusive.
REQ-009 In REFILL with refill_ack=1 and refill valid=1: entry installed that edge, state -> RESP; RESP cycle drives response per REQ-007 from installed entry, then IDLE.
REQ-010 In REFILL with refill_ack=1 and refill valid=0: nothing installed, state -> RESP, response rsp_miss_fault=1, rsp_pa don't-care.
REQ-011 Victim SHALL be the lowest-index invalid entry; if none, round-robin pointer entry; pointer advances (mod NENT) on every install.
REQ-012 rsp_valid SHALL be a single-cycle pulse; exactly one response per accepted request; at most one request outstanding.
REQ-013 inv_all clears every valid bit at the edge; inv_asid clears valid of entries with asid==inv_asid_val and sup==0; both may assert together (union).
REQ-014 Invalidation during REFILL SHALL NOT cancel the walk; the subsequent install still occurs.
REQ-015 On any response with a fault: capture r_fault_vpn=req vpn, r_fault_ins=req_is_pc, r_fault_sup=supmode, r_fault_type=1 miss / 0 protection; capture unchanged otherwise.
REQ-016 reg_read SHALL be {r_fault_vpn, zeros, r_fault_ins, r_fault_sup, r_fault_type, 1'b0}.
REQ-017 refill_ack outside REFILL SHALL be ignored.

Reset
REQ-018 Reset SHALL: clear all entry valid bits, round-robin pointer=0, state=IDLE, fault register=0; outputs rsp_valid=0, refill_req=0, faults=0, req_ready=1 next cycle.
REQ-019 Reset in REFILL or RESP SHALL abandon the request with no response; refill_req=0 the cycle after reset.

Verification (RV=16, VPNW=3, NENT=4, byte addresses)
REQ-020 mmu_enable=0, read 0x4A12 -> one cycle later rsp_pa=0x4A12, no fault.
REQ-021 Empty TLB, asid=1, user read 0x4A12 -> refill_req, refill_tag={0,1,2}; ack data ppn=5,valid,writeable -> rsp_pa=0xAA12; repeat read -> hit, response 1 cycle, no refill_req.
REQ-022 Entry vpn 2 writeable=0, write 0x4000 -> rsp_prot_fault=1, reg_read=0x4000|0x0000 with type bit 0; fetch to executable=0 entry -> prot fault, ins bit=1.
REQ-023 Refill ack with valid=0 -> rsp_miss_fault=1, reg_read[1]=1; five distinct vpns installed -> fifth replaces entry 0, sixth entry 1.
REQ-024 inv_asid with asid 1 -> later asid-1 access refills, supervisor entries still hit; inv_all during REFILL -> install completes, req_ready=0 that cycle.
REQ-025 Reset asserted while refill_req=1 -> refill_req=0 next cycle, no rsp_valid, prior entries miss.
